pwm_multi_channel: RTL and testbench

Parametrised multi-channel PWM generator, successor to the single-duty 16-output PWM peripheral.
- Each channel has its own duty cycle, written through a simple write port into a shadow register. Duty changes are applied glitch-free at period boundaries.
- Runtime-programmable prescaler and edge-/center-aligned counting mode.
- Sits between the SPI register file and the uo_out/uio_out pads.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_prescaler.sv | 42 ++++
 rtl/pwm_multi_channel.sv | 143 ++++++++++++++
 tb/tb_pwm_multi_channel.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and width helpers for the multi-channel PWM generator.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    // Channel index width; a single channel still needs one address bit.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: one-cycle tick every max(div,1) clocks, tolerant of div shrinking mid-count.
module pwm_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] last_s;

    // Terminal count and wrap; >= catches a divider lowered below the running count.
    always_comb begin
        last_s = '0;
        tick   = 1'b0;
        cnt_d  = cnt_q;
        if (div == '0) begin
            last_s = '0;
        end else begin
            last_s = div - DIV_W'(1);
        end
        tick = (cnt_q >= last_s);
        if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: shared edge/center counter, per-channel shadowed duty and registered compare.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int RES_W  = 8,
    parameter int DIV_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             en_out,
    input  logic [NUM_CH-1:0]             en_pwm,
    input  logic [DIV_W-1:0]              prescale_div,
    input  logic                          center_mode,
    input  logic                          duty_wr_en,
    input  logic [ch_idx_w(NUM_CH)-1:0]   duty_wr_ch,
    input  logic [RES_W-1:0]              duty_wr_data,
    output logic [NUM_CH-1:0]             out,
    output logic                          period_start
);

    localparam int               CH_IDX_W = ch_idx_w(NUM_CH);
    localparam logic [RES_W-1:0] MAX      = {RES_W{1'b1}};

    logic             tick_s;
    logic             boundary_s;
    logic [RES_W-1:0] cnt_q, cnt_d;
    pwm_dir_e         dir_q, dir_d;
    pwm_mode_e        mode_q, mode_d;
    logic             period_start_q;

    pwm_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .div   (prescale_div),
        .tick  (tick_s)
    );

    // Counter/direction next state; every boundary restarts at 0 counting up in the newly latched mode.
    always_comb begin
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        mode_d     = mode_q;
        boundary_s = 1'b0;
        if (tick_s) begin
            case (mode_q)
                PWM_EDGE: begin
                    boundary_s = (cnt_q == MAX);
                    cnt_d      = cnt_q + RES_W'(1);
                end
                PWM_CENTER: begin
                    if (dir_q == DIR_UP) begin
                        if (cnt_q == MAX) begin
                            dir_d = DIR_DOWN;
                            cnt_d = cnt_q - RES_W'(1);
                        end else begin
                            cnt_d = cnt_q + RES_W'(1);
                        end
                    end else begin
                        boundary_s = (cnt_q <= RES_W'(1));
                        cnt_d      = cnt_q - RES_W'(1);
                    end
                end
                default: begin
                    boundary_s = 1'b1;
                end
            endcase
            if (boundary_s) begin
                cnt_d  = '0;
                dir_d  = DIR_UP;
                mode_d = center_mode ? PWM_CENTER : PWM_EDGE;
            end else begin
                mode_d = mode_q;
            end
        end else begin
            boundary_s = 1'b0;
        end
    end

    // Counter state and boundary pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            dir_q          <= DIR_UP;
            mode_q         <= PWM_EDGE;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            dir_q          <= dir_d;
            mode_q         <= mode_d;
            period_start_q <= boundary_s;
        end
    end

    assign period_start = period_start_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [RES_W-1:0] shadow_q;
        logic [RES_W-1:0] active_q;
        logic             out_q;
        logic             out_d;
        logic             wr_hit_s;

        // Indices beyond NUM_CH match no channel, so such writes are dropped.
        assign wr_hit_s = duty_wr_en && (duty_wr_ch == CH_IDX_W'(i));

        // Output enable wins, then static-on, then the duty compare with full-on/off extremes.
        always_comb begin
            out_d = 1'b0;
            if (!en_out[i]) begin
                out_d = 1'b0;
            end else if (!en_pwm[i]) begin
                out_d = 1'b1;
            end else if (active_q == MAX) begin
                out_d = 1'b1;
            end else if (active_q == '0) begin
                out_d = 1'b0;
            end else begin
                out_d = (cnt_q < active_q);
            end
        end

        // Shadow takes writes; active copies the pre-write shadow only at a boundary.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_q <= '0;
                active_q <= '0;
                out_q    <= 1'b0;
            end else begin
                if (wr_hit_s) begin
                    shadow_q <= duty_wr_data;
                end
                if (boundary_s) begin
                    active_q <= shadow_q;
                end
                out_q <= out_d;
            end
        end

        assign out[i] = out_q;
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel: duty ratios, shadow timing, center mode, prescaler, reset.
module tb_pwm_multi_channel;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [15:0] prescale_div;
    logic        center_mode;
    logic        duty_wr_en;
    logic [3:0]  duty_wr_ch;
    logic [7:0]  duty_wr_data;
    logic [15:0] out;
    logic        period_start;

    int checks = 0;
    int errors = 0;
    int hi   [16];
    int rise [16];
    int ps_cnt;
    logic [15:0] or_out;
    int k;

    typedef struct {
        int k;
        int ch;
        int d;
    } wr_t;
    wr_t wq[$];

    pwm_multi_channel #(.NUM_CH(16), .RES_W(8), .DIV_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_out       (en_out),
        .en_pwm       (en_pwm),
        .prescale_div (prescale_div),
        .center_mode  (center_mode),
        .duty_wr_en   (duty_wr_en),
        .duty_wr_ch   (duty_wr_ch),
        .duty_wr_data (duty_wr_data),
        .out          (out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sched(input int wk, input int ch, input int d);
        wr_t w;
        w.k  = wk;
        w.ch = ch;
        w.d  = d;
        wq.push_back(w);
    endtask

    // Run n clocks, applying scheduled writes, and tally per-channel highs/rises and period pulses.
    task automatic run(input int n);
        logic [15:0] prev;
        prev   = out;
        ps_cnt = 0;
        or_out = 16'h0000;
        for (int c = 0; c < 16; c++) begin
            hi[c]   = 0;
            rise[c] = 0;
        end
        for (int s = 1; s <= n; s++) begin
            if (wq.size() > 0 && wq[0].k == s) begin
                duty_wr_en   = 1'b1;
                duty_wr_ch   = 4'(wq[0].ch);
                duty_wr_data = 8'(wq[0].d);
                void'(wq.pop_front());
            end
            @(posedge clk);
            #1;
            duty_wr_en = 1'b0;
            for (int c = 0; c < 16; c++) begin
                hi[c] += int'(out[c]);
                if (out[c] && !prev[c]) rise[c]++;
            end
            prev    = out;
            or_out |= out;
            ps_cnt += int'(period_start);
        end
    endtask

    task automatic wait_ps(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (period_start === 1'b1) break;
        end
    endtask

    task automatic wait_low(input int ch, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (out[ch] === 1'b0) break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        en_out       = 16'hFFFF;
        en_pwm       = 16'hFFFF;
        prescale_div = 16'd2;
        center_mode  = 1'b1;
        duty_wr_en   = 1'b1;
        duty_wr_ch   = 4'd5;
        duty_wr_data = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_ps", 32'(period_start), 32'd0);

        duty_wr_en  = 1'b0;
        center_mode = 1'b0;
        en_out      = 16'h0000;
        en_pwm      = 16'h0000;
        rst_n       = 1'b1;
        wait_ps(600, k);
        chk("first_ps_d2", 32'(k), 32'd512);

        // Edge mode, D=1; a duty written now only applies at the next boundary.
        prescale_div = 16'd1;
        en_out       = 16'h0001;
        en_pwm       = 16'h0001;
        sched(1, 0, 64);
        run(256);
        chk("w1_hi0", 32'(hi[0]), 32'd0);
        chk("w1_ps", 32'(ps_cnt), 32'd1);
        chk("w1_ps_end", 32'(period_start), 32'd1);
        sched(1, 0, 255);
        run(256);
        chk("duty64_hi0", 32'(hi[0]), 32'd64);
        chk("duty64_ps", 32'(ps_cnt), 32'd1);
        sched(1, 0, 0);
        run(256);
        chk("duty255_hi0", 32'(hi[0]), 32'd256);
        chk("duty255_ps_end", 32'(period_start), 32'd1);

        // Per-channel enables.
        en_out = 16'h0009;
        en_pwm = 16'hFFF7;
        sched(1, 0, 32);
        sched(2, 5, 200);
        run(256);
        chk("duty0_hi0", 32'(hi[0]), 32'd0);
        chk("static_hi3_a", 32'(hi[3]), 32'd256);
        run(256);
        chk("ch_hi0", 32'(hi[0]), 32'd32);
        chk("ch_hi3", 32'(hi[3]), 32'd256);
        chk("ch_hi5_disabled", 32'(hi[5]), 32'd0);
        chk("ch_others_low", 32'(or_out & 16'hFFF6), 32'd0);

        // Shadow timing: mid-period write, then a write in the boundary clock.
        sched(100, 0, 100);
        run(256);
        chk("shadow_mid_hold", 32'(hi[0]), 32'd32);
        sched(256, 0, 128);
        run(256);
        chk("shadow_mid_apply", 32'(hi[0]), 32'd100);
        chk("shadow_bnd_ps_end", 32'(period_start), 32'd1);
        run(256);
        chk("shadow_bnd_old", 32'(hi[0]), 32'd100);
        chk("shadow_bnd_rise", 32'(rise[0]), 32'd1);

        // Mode change requested mid-period must not disturb the current edge period.
        center_mode = 1'b1;
        sched(10, 0, 100);
        run(256);
        chk("shadow_bnd_new", 32'(hi[0]), 32'd128);
        chk("mode_hold_ps", 32'(ps_cnt), 32'd1);
        chk("mode_hold_ps_end", 32'(period_start), 32'd1);

        // Center mode: counter 0..255..1, out=cnt<100 gives 100 up + 99 down samples.
        center_mode = 1'b0;
        sched(1, 1, 1);
        sched(2, 2, 2);
        sched(3, 3, 3);
        sched(4, 4, 4);
        run(510);
        chk("center_hi0", 32'(hi[0]), 32'd199);
        chk("center_rise0", 32'(rise[0]), 32'd2);
        chk("center_ps", 32'(ps_cnt), 32'd1);
        chk("center_ps_end", 32'(period_start), 32'd1);

        // Back to edge with D=0 treated as 1.
        en_out       = 16'h001F;
        en_pwm       = 16'h001F;
        prescale_div = 16'd0;
        run(256);
        chk("d0_hi0", 32'(hi[0]), 32'd100);
        chk("d0_hi1", 32'(hi[1]), 32'd1);
        chk("d0_hi2", 32'(hi[2]), 32'd2);
        chk("d0_ps", 32'(ps_cnt), 32'd1);
        chk("d0_ps_end", 32'(period_start), 32'd1);

        // Prescaler D=3334: counter steps observed through falls of channels with duty 1..4.
        prescale_div = 16'd3334;
        wait_low(1, 4000, k);
        chk("presc_first_tick", 32'(k), 32'd3335);
        wait_low(2, 4000, k);
        chk("presc_tick_period", 32'(k), 32'd3334);
        repeat (499) @(posedge clk);
        #1;
        prescale_div = 16'd10;
        wait_low(3, 50, k);
        chk("presc_lower_next", 32'(k), 32'd2);
        wait_low(4, 50, k);
        chk("presc_lower_period", 32'(k), 32'd10);

        // Asynchronous reset mid-period.
        chk("pre_rst_out0", 32'(out[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", 32'(out), 32'd0);
        chk("async_rst_ps", 32'(period_start), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
